// File: rtl/exibicao_pkg.sv
// Shared definitions for the sequence replay controller: state encodings
// (also driven out on db_estado) and the timer width helper.
package exibicao_pkg;

    localparam logic [3:0] EST_OCIOSO  = 4'd0;
    localparam logic [3:0] EST_PREPARA = 4'd1;
    localparam logic [3:0] EST_ACESO   = 4'd2;
    localparam logic [3:0] EST_APAGADO = 4'd3;
    localparam logic [3:0] EST_PROXIMO = 4'd4;
    localparam logic [3:0] EST_FIM     = 4'd5;

    typedef enum logic [3:0] {
        OCIOSO  = EST_OCIOSO,
        PREPARA = EST_PREPARA,
        ACESO   = EST_ACESO,
        APAGADO = EST_APAGADO,
        PROXIMO = EST_PROXIMO,
        FIM     = EST_FIM
    } estado_t;

    // Wide enough to hold the longest phase length without wrapping.
    function automatic int largura_timer(input int t_aceso, input int t_apagado);
        int maior;
        maior = (t_aceso > t_apagado) ? t_aceso : t_apagado;
        return $clog2(maior + 1);
    endfunction

endpackage

// File: rtl/temporizador_exibicao.sv
// Phase timer for the replay controller: up-counter with synchronous clear,
// count enable and a terminal-count flag against a caller-selected value.
module temporizador_exibicao #(
    parameter int LARGURA = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpar,
    input  logic               habilitar,
    input  logic [LARGURA-1:0] terminal,
    output logic               fim_contagem
);

    logic [LARGURA-1:0] contagem;

    // Clear has priority over counting so every phase starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            contagem <= '0;
        else if (limpar)
            contagem <= '0;
        else if (habilitar)
            contagem <= contagem + 1'b1;
    end

    assign fim_contagem = (contagem == terminal);

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// Replays the stored sequence on the LEDs before each player round, walking
// the datapath address counter from 0 up to the round limit.
// Optional build macro EXIBICAO_PAUSA_EN adds a pausar input that freezes
// the lit/dark phases while high.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// PREPARA | clear address counter
// ACESO   | show current entry for T_ACESO cycles
// APAGADO | dark gap for T_APAGADO cycles, then test the limit
// PROXIMO | advance address counter
// FIM     | one-cycle pronto pulse
module controle_exibicao_sequencia
    import exibicao_pkg::*;
#(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 250,
    parameter int DADO_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
`ifdef EXIBICAO_PAUSA_EN
    input  logic              pausar,
`endif
    input  logic              enderecoIgualLimite,
    input  logic [DADO_W-1:0] dado,
    output logic              zeraE,
    output logic              contaE,
    output logic [DADO_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int TW = largura_timer(T_ACESO, T_APAGADO);

    estado_t        estado, proximo;
    logic           pausa;
    logic           contando;
    logic           fim_fase;
    logic [TW-1:0]  terminal;

`ifdef EXIBICAO_PAUSA_EN
    assign pausa = pausar;
`else
    assign pausa = 1'b0;
`endif

    assign contando = (estado == ACESO) || (estado == APAGADO);
    assign terminal = (estado == APAGADO) ? TW'(T_APAGADO - 1) : TW'(T_ACESO - 1);

    // Timer restarts on every state change and stays at zero outside the timed phases.
    temporizador_exibicao #(.LARGURA(TW)) u_timer (
        .clock        (clock),
        .reset        (reset),
        .limpar       (cancelar || (proximo != estado) || !contando),
        .habilitar    (contando && !pausa),
        .terminal     (terminal),
        .fim_contagem (fim_fase)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    // Next-state logic; cancelar overrides everything, unused codes fall back to idle.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (iniciar) proximo = PREPARA;
            PREPARA: proximo = ACESO;
            ACESO:   if (fim_fase && !pausa) proximo = APAGADO;
            APAGADO: if (fim_fase && !pausa) proximo = enderecoIgualLimite ? FIM : PROXIMO;
            PROXIMO: proximo = ACESO;
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
        if (cancelar)
            proximo = OCIOSO;
    end

    // Moore output decode from the registered state.
    always_comb begin
        zeraE    = 1'b0;
        contaE   = 1'b0;
        leds     = '0;
        exibindo = 1'b0;
        pronto   = 1'b0;
        case (estado)
            PREPARA: begin zeraE = 1'b1;  exibindo = 1'b1; end
            ACESO:   begin leds = dado;   exibindo = 1'b1; end
            APAGADO: exibindo = 1'b1;
            PROXIMO: begin contaE = 1'b1; exibindo = 1'b1; end
            FIM:     pronto = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// Bench for controle_exibicao_sequencia with a small address-counter/memory
// model standing in for the datapath. Expected per-cycle output words are
// queued when a replay is launched and popped as the design runs.
module tb_controle_exibicao_sequencia;

    localparam int TA = 4;
    localparam int TP = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       cancelar;
    logic       pausar;
    logic       enderecoIgualLimite;
    logic [3:0] dado;
    logic       zeraE, contaE, exibindo, pronto;
    logic [3:0] leds, db_estado;

    logic [3:0]  mem [8];
    int          addr = 0;
    int          limite = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          idx_pronto;
    logic [11:0] q_exp [$];
    logic [11:0] obs;

    always #5 clock = ~clock;

    controle_exibicao_sequencia #(
        .T_ACESO   (TA),
        .T_APAGADO (TP),
        .DADO_W    (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .cancelar            (cancelar),
`ifdef EXIBICAO_PAUSA_EN
        .pausar              (pausar),
`endif
        .enderecoIgualLimite (enderecoIgualLimite),
        .dado                (dado),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .leds                (leds),
        .exibindo            (exibindo),
        .pronto              (pronto),
        .db_estado           (db_estado)
    );

    // datapath model: address counter, memory read, limit compare
    always @(posedge clock) begin
        if (zeraE)
            addr <= 0;
        else if (contaE)
            addr <= addr + 1;
    end
    assign dado                = mem[addr[2:0]];
    assign enderecoIgualLimite = (addr == limite);
    assign obs                 = {leds, zeraE, contaE, pronto, exibindo, db_estado};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, req);
    endtask

    task automatic push(input logic [3:0] est, input logic [3:0] l,
                        input logic z, input logic c, input logic p, input logic e);
        q_exp.push_back({l, z, c, p, e, est});
    endtask

    // reference replay: PREPARA, (ACESO, APAGADO, PROXIMO)*, FIM, idle
    task automatic build(input int lim, input int pause_len, input bit hold);
        push(4'd1, 4'd0, 1, 0, 0, 1);
        for (int i = 0; i <= lim; i++) begin
            repeat (TA + ((i == 0) ? pause_len : 0)) push(4'd2, mem[i], 0, 0, 0, 1);
            repeat (TP) push(4'd3, 4'd0, 0, 0, 0, 1);
            if (i < lim) push(4'd4, 4'd0, 0, 1, 0, 1);
        end
        push(4'd5, 4'd0, 0, 0, 1, 0);
        push(4'd0, 4'd0, 0, 0, 0, 0);
        if (hold) push(4'd1, 4'd0, 1, 0, 0, 1);
        else      push(4'd0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic run_case(input string nome, input int lim, input bit hold,
                            input int abort_at, input bit abort_rst,
                            input int pause_at, input int pause_len);
        int idx;
        logic [11:0] req;
        limite = lim;
        idx_pronto = -1;
        q_exp.delete();
        build(lim, pause_len, hold);
        if (hold) abort_at = q_exp.size() - 1;
        if (abort_at >= 0) begin
            while (q_exp.size() > abort_at + 1) void'(q_exp.pop_back());
            repeat (2) push(4'd0, 4'd0, 0, 0, 0, 0);
        end
        @(negedge clock);
        iniciar = 1'b1;
        idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clock);
            req = q_exp.pop_front();
            check_val($sformatf("%s[%0d]", nome, idx), {20'd0, obs}, {20'd0, req});
            if (pronto) idx_pronto = idx;
            if (idx == 0 && !hold) iniciar = 1'b0;
            if (pause_len > 0 && idx == pause_at) pausar = 1'b1;
            if (pause_len > 0 && idx == pause_at + pause_len) pausar = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                iniciar = 1'b0;
                if (abort_rst) begin
                    #3 reset = 1'b1;
                    #1 check_val($sformatf("%s_rst_imediato", nome), {20'd0, obs}, 32'd0);
                end else begin
                    cancelar = 1'b1;
                end
            end
            if (abort_at >= 0 && idx == abort_at + 1) begin
                reset    = 1'b0;
                cancelar = 1'b0;
            end
            idx++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        iniciar  = 1'b0;
        cancelar = 1'b0;
        pausar   = 1'b0;
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
        mem[4] = 4'd3; mem[5] = 4'd5; mem[6] = 4'd6; mem[7] = 4'd9;

        #12 check_val("reset_saidas", {20'd0, obs}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("pos_reset", {20'd0, obs}, 32'd0);

        // three entries, limit after the third
        run_case("t1", 2, 0, -1, 0, 0, 0);
        check_val("t1_pronto_ciclo", idx_pronto, 21);

        // limit 0: single entry
        mem[0] = 4'd8;
        run_case("t2", 0, 0, -1, 0, 0, 0);
        mem[0] = 4'd1;

        // cancel in 2nd lit cycle of entry 2, then a fresh replay
        run_case("t3", 2, 0, 9, 0, 0, 0);
        run_case("t3_novo", 1, 0, -1, 0, 0, 0);

        // cancelar wins over iniciar in idle
        @(negedge clock);
        iniciar  = 1'b1;
        cancelar = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_val("cancela_ocioso", {20'd0, obs}, 32'd0);
        end
        iniciar  = 1'b0;
        cancelar = 1'b0;

        // iniciar held: one replay, then restart only after idle
        run_case("t4", 1, 1, -1, 0, 0, 0);

        // async reset in the first dark cycle, then a normal replay
        run_case("t5", 2, 0, 5, 1, 0, 0);
        run_case("t5_novo", 2, 0, -1, 0, 0, 0);

`ifdef EXIBICAO_PAUSA_EN
        // pause five cycles inside the first lit phase
        run_case("t6", 2, 0, -1, 0, 2, 5);
        check_val("t6_pronto_ciclo", idx_pronto, 26);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
